// File: rtl/load_data_queue_if.sv
// Shared LDQ types and the dispatch/exec/issue port bundle of the load queue.
package core_pkg;
    parameter int LDQ_ENTRIES = 16;
    parameter int SDQ_ENTRIES = 16;
    localparam int LDQ_IDX_W = $clog2(LDQ_ENTRIES);
    localparam int SDQ_MRK_W = $clog2(SDQ_ENTRIES) + 1;

    typedef struct packed {
        logic                 valid;
        logic                 addr_vld;
        logic [31:0]          addr;
        logic [SDQ_MRK_W-1:0] sdq_marker;
    } ldq_entry_t;
endpackage

interface load_data_queue_if;
    import core_pkg::*;

    logic                 flush_i;
    logic                 disp_vld_i;
    logic [SDQ_MRK_W-1:0] disp_sdq_marker_i;
    logic [LDQ_IDX_W-1:0] ldq_disp_idx_o;
    logic                 ldq_full_o;
    logic                 exec_vld_i;
    logic [LDQ_IDX_W-1:0] exec_ldq_idx_i;
    logic [31:0]          exec_addr_i;
    logic                 issue_en_i;
    ldq_entry_t           issue_entry_o;
    logic                 issue_vld_o;

    modport master (
        output flush_i, disp_vld_i, disp_sdq_marker_i,
        output exec_vld_i, exec_ldq_idx_i, exec_addr_i,
        output issue_en_i,
        input  ldq_disp_idx_o, ldq_full_o,
        input  issue_entry_o, issue_vld_o
    );

    modport slave (
        input  flush_i, disp_vld_i, disp_sdq_marker_i,
        input  exec_vld_i, exec_ldq_idx_i, exec_addr_i,
        input  issue_en_i,
        output ldq_disp_idx_o, ldq_full_o,
        output issue_entry_o, issue_vld_o
    );
endinterface

// File: rtl/load_data_queue.sv
// In-order circular load queue: allocate at dispatch, fill address at
// execute, issue and dequeue the oldest entry once its address is known.
module load_data_queue
    import core_pkg::*;
(
    input logic             clk_i,
    input logic             rst_i,
    load_data_queue_if.slave ldq_if
);
    localparam int IW = LDQ_IDX_W;
    localparam logic [IW:0] FULL_CNT = (IW+1)'(LDQ_ENTRIES);

    ldq_entry_t    ent_q [LDQ_ENTRIES];
    ldq_entry_t    ent_d [LDQ_ENTRIES];
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [IW:0]   cnt_q, cnt_d;
    ldq_entry_t    head_ent;
    logic          full;
    logic          issue_vld;
    logic          disp_ok;
    logic          deq;

    assign head_ent  = ent_q[head_q];
    assign full      = (cnt_q == FULL_CNT);
    assign issue_vld = head_ent.valid && head_ent.addr_vld;
    assign disp_ok   = ldq_if.disp_vld_i && !full;
    assign deq       = issue_vld && ldq_if.issue_en_i;

    assign ldq_if.ldq_disp_idx_o = tail_q;
    assign ldq_if.ldq_full_o     = full;
    assign ldq_if.issue_entry_o  = head_ent;
    assign ldq_if.issue_vld_o    = issue_vld;

    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (ldq_if.flush_i) begin
            for (int i = 0; i < LDQ_ENTRIES; i++) begin
                ent_d[i] = '0;
            end
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            // exec checks the pre-edge valid bit, so it never hits a slot
            // being allocated in the same cycle
            if (ldq_if.exec_vld_i && ent_q[ldq_if.exec_ldq_idx_i].valid) begin
                ent_d[ldq_if.exec_ldq_idx_i].addr     = ldq_if.exec_addr_i;
                ent_d[ldq_if.exec_ldq_idx_i].addr_vld = 1'b1;
            end
            if (disp_ok) begin
                ent_d[tail_q].valid      = 1'b1;
                ent_d[tail_q].addr_vld   = 1'b0;
                ent_d[tail_q].addr       = '0;
                ent_d[tail_q].sdq_marker = ldq_if.disp_sdq_marker_i;
                tail_d = tail_q + 1'b1;
            end
            if (deq) begin
                ent_d[head_q] = '0;
                head_d = head_q + 1'b1;
            end
            cnt_d = cnt_q + (IW+1)'(disp_ok) - (IW+1)'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < LDQ_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent_q  <= ent_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_load_data_queue.sv
// Randomized and directed bench for load_data_queue against a queue-based model.
module tb_load_data_queue;
    import core_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;

    load_data_queue_if bus ();

    load_data_queue dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ldq_if (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [SDQ_MRK_W-1:0] mrk;
        bit                   av;
        logic [31:0]          addr;
    } m_ent_t;

    m_ent_t mq[$];
    int     mhead;
    int     n_chk = 0;
    int     n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ldq_entry_t e;
        bit         vld;
        e   = '0;
        vld = 0;
        if (mq.size() > 0) begin
            e.valid      = 1'b1;
            e.addr_vld   = mq[0].av;
            e.addr       = mq[0].addr;
            e.sdq_marker = mq[0].mrk;
            vld          = mq[0].av;
        end
        chk("full", 64'(bus.ldq_full_o), 64'(mq.size() == LDQ_ENTRIES));
        chk("disp_idx", 64'(bus.ldq_disp_idx_o),
            64'((mhead + mq.size()) % LDQ_ENTRIES));
        chk("issue_vld", 64'(bus.issue_vld_o), 64'(vld));
        chk("issue_entry", 64'(bus.issue_entry_o), 64'(e));
    endtask

    task automatic model_edge(input bit rst, input bit fl, input bit dv,
                              input logic [SDQ_MRK_W-1:0] mk, input bit ev,
                              input logic [LDQ_IDX_W-1:0] ei,
                              input logic [31:0] ea, input bit ie);
        bit     was_full;
        bit     deq;
        int     off;
        m_ent_t n;
        if (rst || fl) begin
            mq.delete();
            mhead = 0;
            return;
        end
        was_full = (mq.size() == LDQ_ENTRIES);
        deq      = (mq.size() > 0) && mq[0].av && ie;
        off      = (int'(ei) - mhead + LDQ_ENTRIES) % LDQ_ENTRIES;
        if (ev && off < mq.size()) begin
            mq[off].av   = 1;
            mq[off].addr = ea;
        end
        if (dv && !was_full) begin
            n.mrk  = mk;
            n.av   = 0;
            n.addr = '0;
            mq.push_back(n);
        end
        if (deq) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % LDQ_ENTRIES;
        end
    endtask

    task automatic cyc(input bit rst, input bit fl, input bit dv,
                       input logic [SDQ_MRK_W-1:0] mk, input bit ev,
                       input logic [LDQ_IDX_W-1:0] ei,
                       input logic [31:0] ea, input bit ie);
        rst_i                 = !rst;
        bus.flush_i           = fl;
        bus.disp_vld_i        = dv;
        bus.disp_sdq_marker_i = mk;
        bus.exec_vld_i        = ev;
        bus.exec_ldq_idx_i    = ei;
        bus.exec_addr_i       = ea;
        bus.issue_en_i        = ie;
        @(posedge clk_i);
        model_edge(rst, fl, dv, mk, ev, ei, ea, ie);
        @(negedge clk_i);
        check_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, '0, 0, '0, '0, 0);
    endtask

    initial begin
        mhead = 0;
        cyc(1, 0, 0, '0, 0, '0, '0, 0);
        cyc(1, 0, 0, '0, 0, '0, '0, 0);
        chk("rst_full", 64'(bus.ldq_full_o), 64'(0));
        chk("rst_vld", 64'(bus.issue_vld_o), 64'(0));
        chk("rst_idx", 64'(bus.ldq_disp_idx_o), 64'(0));

        // single load
        cyc(0, 0, 1, 5'd5, 0, '0, '0, 0);
        chk("single_idx", 64'(bus.ldq_disp_idx_o), 64'(1));
        chk("single_novld", 64'(bus.issue_vld_o), 64'(0));
        cyc(0, 0, 0, '0, 1, 4'd0, 32'd5108, 1);
        chk("single_vld", 64'(bus.issue_vld_o), 64'(1));
        chk("single_addr", 64'(bus.issue_entry_o.addr), 64'(5108));
        chk("single_mrk", 64'(bus.issue_entry_o.sdq_marker), 64'(5));
        cyc(0, 0, 0, '0, 0, '0, '0, 1);
        chk("single_empty", 64'(bus.issue_vld_o), 64'(0));

        // exec to an empty queue
        cyc(0, 0, 0, '0, 1, 4'd15, 32'd5108, 1);
        chk("inv_exec_vld", 64'(bus.issue_vld_o), 64'(0));
        chk("inv_exec_idx", 64'(bus.ldq_disp_idx_o), 64'(1));

        // fill from index 0
        cyc(1, 0, 0, '0, 0, '0, '0, 0);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 0, 1, 5'd5, 0, '0, '0, 0);
        end
        chk("fill_full", 64'(bus.ldq_full_o), 64'(1));
        chk("fill_idx", 64'(bus.ldq_disp_idx_o), 64'(0));

        // drain in order
        for (int i = 0; i < LDQ_ENTRIES; i++) begin
            cyc(0, 0, 0, '0, 1, LDQ_IDX_W'(i), 32'(i * 3), 1);
            if (i == 1) chk("drain_notfull", 64'(bus.ldq_full_o), 64'(0));
        end
        idle();
        cyc(0, 0, 0, '0, 0, '0, '0, 1);
        chk("drain_empty", 64'(bus.issue_vld_o), 64'(0));

        // flush with a partially filled queue
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 5'(i), 0, '0, '0, 0);
        cyc(0, 0, 0, '0, 1, 4'd2, 32'hAA, 0);
        cyc(0, 0, 0, '0, 1, 4'd3, 32'hBB, 0);
        cyc(0, 1, 1, 5'd9, 0, '0, '0, 1);
        chk("flush_idx", 64'(bus.ldq_disp_idx_o), 64'(0));
        chk("flush_vld", 64'(bus.issue_vld_o), 64'(0));
        chk("flush_full", 64'(bus.ldq_full_o), 64'(0));

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bit                   r, f, dv, ev, ie;
            logic [LDQ_IDX_W-1:0] ei;
            r  = ($urandom % 700) == 0;
            f  = ($urandom % 90) == 0;
            dv = ($urandom % 100) < 55;
            ev = ($urandom % 100) < 70;
            ie = ($urandom % 100) < 60;
            if ($urandom % 2)
                ei = LDQ_IDX_W'((mhead + $urandom % (mq.size() + 1))
                                % LDQ_ENTRIES);
            else
                ei = LDQ_IDX_W'($urandom);
            cyc(r, f, dv, SDQ_MRK_W'($urandom), ev, ei, $urandom, ie);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
